// File: rtl/conv_t2d_pkg.sv
// Shared types and elaboration helpers for the transposed-2D-conv tap scheduler.
package conv_t2d_pkg;

    localparam int CMD_ADDR_W = 16;
    localparam int OFS_W      = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef struct packed {
        logic [CMD_ADDR_W-1:0] in_addr;
        logic [CMD_ADDR_W-1:0] w_addr;
        logic [CMD_ADDR_W-1:0] out_addr;
        logic                  zero;
        logic                  first;
        logic                  last;
    } cmd_t;

    function automatic int out_dim(input int in_sz, input int stride, input int pad,
                                   input int dil, input int k, input int opad);
        return (in_sz - 1) * stride - 2 * pad + dil * (k - 1) + opad + 1;
    endfunction

    function automatic bit is_pow2(input int v);
        return (v == 1) || (v == 2) || (v == 4) || (v == 8);
    endfunction

endpackage

// File: rtl/conv_t2d_axis_decode.sv
// Maps one axis tap offset n = o + PAD - k*DIL to its validity and input index.
// The scaled offset lets the caller obtain index*ROW_PITCH with the same shift.
module conv_t2d_axis_decode
    import conv_t2d_pkg::*;
#(
    parameter int STRIDE = 1,
    parameter int IN_SZ  = 1,
    parameter int ADDR_W = 16
) (
    input  logic signed [OFS_W-1:0] i_ofs,
    input  logic signed [OFS_W-1:0] i_scaled,
    output logic                    o_valid,
    output logic [ADDR_W-1:0]       o_idx
);

    localparam int                      SHIFT = $clog2(STRIDE);
    localparam logic signed [OFS_W-1:0] MASK  = OFS_W'(STRIDE - 1);
    localparam logic signed [OFS_W-1:0] BOUND = OFS_W'(IN_SZ);

    logic signed [OFS_W-1:0] w_div;

    // Stride is a power of two, so mod/div reduce to a mask and an arithmetic shift.
    always_comb begin
        w_div   = i_ofs >>> SHIFT;
        o_valid = !i_ofs[OFS_W-1] && ((i_ofs & MASK) == '0) && (w_div < BOUND);
        o_idx   = ADDR_W'(i_scaled >>> SHIFT);
    end

endmodule

// File: rtl/conv_transposed_2d_tap_scheduler.sv
// Loop sequencer for the transposed-conv MAC datapath: one command beat per
// (oc,oh,ow,ic,kh,kw), addresses built from running counters and strides.
module conv_transposed_2d_tap_scheduler
    import conv_t2d_pkg::*;
#(
    parameter int IN_H     = 2,
    parameter int IN_W     = 3,
    parameter int C_IN     = 1,
    parameter int C_OUT    = 1,
    parameter int KH       = 2,
    parameter int KW       = 3,
    parameter int STRIDE_H = 2,
    parameter int STRIDE_W = 1,
    parameter int PAD_H    = 0,
    parameter int PAD_W    = 0,
    parameter int DIL_H    = 1,
    parameter int DIL_W    = 1,
    parameter int OPAD_H   = 0,
    parameter int OPAD_W   = 0,
    parameter int ADDR_W   = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_abort,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_cmd_valid,
    input  logic              i_cmd_ready,
    output logic [ADDR_W-1:0] o_cmd_in_addr,
    output logic [ADDR_W-1:0] o_cmd_w_addr,
    output logic [ADDR_W-1:0] o_cmd_out_addr,
    output logic              o_cmd_zero,
    output logic              o_cmd_first,
    output logic              o_cmd_last
);

    localparam int     OH        = out_dim(IN_H, STRIDE_H, PAD_H, DIL_H, KH, OPAD_H);
    localparam int     OW        = out_dim(IN_W, STRIDE_W, PAD_W, DIL_W, KW, OPAD_W);
    localparam longint ADDR_SPAN = longint'(1) << ADDR_W;

    if (!is_pow2(STRIDE_H) || !is_pow2(STRIDE_W)) begin : g_bad_stride
        $error("stride must be 1, 2, 4 or 8");
    end
    if (!(OPAD_H < STRIDE_H || OPAD_H < DIL_H) || !(OPAD_W < STRIDE_W || OPAD_W < DIL_W)) begin : g_bad_opad
        $error("output padding must be smaller than stride or dilation");
    end
    if (ADDR_W != CMD_ADDR_W) begin : g_bad_addr_w
        $error("ADDR_W must match the command struct address width");
    end
    if (longint'(C_IN) * IN_H * IN_W > ADDR_SPAN || longint'(C_IN) * C_OUT * KH * KW > ADDR_SPAN ||
        longint'(C_OUT) * OH * OW > ADDR_SPAN) begin : g_bad_size
        $error("tensor does not fit in ADDR_W address space");
    end

    localparam logic [ADDR_W-1:0] ONE        = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] KW_MAX     = ADDR_W'(KW - 1);
    localparam logic [ADDR_W-1:0] KH_MAX     = ADDR_W'(KH - 1);
    localparam logic [ADDR_W-1:0] IC_MAX     = ADDR_W'(C_IN - 1);
    localparam logic [ADDR_W-1:0] OW_MAX     = ADDR_W'(OW - 1);
    localparam logic [ADDR_W-1:0] OH_MAX     = ADDR_W'(OH - 1);
    localparam logic [ADDR_W-1:0] OC_MAX     = ADDR_W'(C_OUT - 1);
    localparam logic [ADDR_W-1:0] W_OC_STEP  = ADDR_W'(KH * KW);
    localparam logic [ADDR_W-1:0] W_IC_STEP  = ADDR_W'(C_OUT * KH * KW);
    localparam logic [ADDR_W-1:0] IN_IC_STEP = ADDR_W'(IN_H * IN_W);
    localparam logic [OFS_W-1:0]  NH0        = OFS_W'(PAD_H);
    localparam logic [OFS_W-1:0]  AH0        = OFS_W'(PAD_H * IN_W);
    localparam logic [OFS_W-1:0]  AH_OH_STEP = OFS_W'(IN_W);
    localparam logic [OFS_W-1:0]  AH_K_STEP  = OFS_W'(DIL_H * IN_W);
    localparam logic [OFS_W-1:0]  NH_K_STEP  = OFS_W'(DIL_H);
    localparam logic [OFS_W-1:0]  NW0        = OFS_W'(PAD_W);
    localparam logic [OFS_W-1:0]  NW_K_STEP  = OFS_W'(DIL_W);

    // ah tracks nh*IN_W so that an exactly divisible offset yields ih*IN_W by shifting.
    typedef struct packed {
        logic [ADDR_W-1:0] oc, oh, ow, ic, kh, kw;
        logic [ADDR_W-1:0] out_addr, w_oc, w_ic, w_k, in_ic;
        logic [OFS_W-1:0]  nh_base, nh, ah_base, ah, nw_base, nw;
    } loop_t;

    localparam loop_t LOOP_INIT = '{oc: '0, oh: '0, ow: '0, ic: '0, kh: '0, kw: '0,
                                    out_addr: '0, w_oc: '0, w_ic: '0, w_k: '0, in_ic: '0,
                                    nh_base: NH0, nh: NH0, ah_base: AH0, ah: AH0,
                                    nw_base: NW0, nw: NW0};

    state_t            r_state, w_state_nxt;
    loop_t             r_loop, w_nxt;
    cmd_t              r_cmd, w_cmd;
    logic              w_c_kw, w_c_kh, w_c_ic, w_c_ow, w_c_oh, w_c_oc;
    logic              w_fire, w_final, w_start;
    logic              w_valid_h, w_valid_w;
    logic [ADDR_W-1:0] w_row, w_col;

    assign w_c_kw  = r_loop.kw == KW_MAX;
    assign w_c_kh  = w_c_kw && (r_loop.kh == KH_MAX);
    assign w_c_ic  = w_c_kh && (r_loop.ic == IC_MAX);
    assign w_c_ow  = w_c_ic && (r_loop.ow == OW_MAX);
    assign w_c_oh  = w_c_ow && (r_loop.oh == OH_MAX);
    assign w_c_oc  = w_c_oh && (r_loop.oc == OC_MAX);
    assign w_fire  = (r_state == RUN) && i_cmd_ready;
    assign w_final = w_fire && w_c_oc;
    assign w_start = (r_state == IDLE) && i_start && !i_abort;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        o_cmd_valid = 1'b0;
        case (r_state)
            IDLE: if (w_start) w_state_nxt = RUN;
            RUN: begin
                o_busy      = 1'b1;
                o_cmd_valid = 1'b1;
                if (i_abort)      w_state_nxt = IDLE;
                else if (w_final) w_state_nxt = DONE;
            end
            DONE: begin
                o_busy      = 1'b1;
                o_done      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Each counter wraps at its bound and carries outward in the same cycle.
    always_comb begin
        w_nxt = r_loop;
        if (w_fire) begin
            w_nxt.kw  = w_c_kw ? '0 : r_loop.kw + ONE;
            w_nxt.w_k = w_c_kh ? '0 : r_loop.w_k + ONE;
            if (w_c_kw) w_nxt.kh = w_c_kh ? '0 : r_loop.kh + ONE;
            if (w_c_kh) begin
                w_nxt.ic    = w_c_ic ? '0 : r_loop.ic + ONE;
                w_nxt.w_ic  = w_c_ic ? '0 : r_loop.w_ic + W_IC_STEP;
                w_nxt.in_ic = w_c_ic ? '0 : r_loop.in_ic + IN_IC_STEP;
            end
            if (w_c_ic) begin
                w_nxt.ow       = w_c_ow ? '0 : r_loop.ow + ONE;
                w_nxt.out_addr = r_loop.out_addr + ONE;
                w_nxt.nw_base  = w_c_ow ? NW0 : r_loop.nw_base + OFS_W'(1);
            end
            if (w_c_ow) begin
                w_nxt.oh      = w_c_oh ? '0 : r_loop.oh + ONE;
                w_nxt.nh_base = w_c_oh ? NH0 : r_loop.nh_base + OFS_W'(1);
                w_nxt.ah_base = w_c_oh ? AH0 : r_loop.ah_base + AH_OH_STEP;
            end
            if (w_c_oh) begin
                w_nxt.oc   = r_loop.oc + ONE;
                w_nxt.w_oc = r_loop.w_oc + W_OC_STEP;
            end
            w_nxt.nw = w_c_kw ? w_nxt.nw_base : r_loop.nw - NW_K_STEP;
            if (w_c_kw) begin
                w_nxt.nh = w_c_kh ? w_nxt.nh_base : r_loop.nh - NH_K_STEP;
                w_nxt.ah = w_c_kh ? w_nxt.ah_base : r_loop.ah - AH_K_STEP;
            end
        end
    end

    conv_t2d_axis_decode #(.STRIDE(STRIDE_H), .IN_SZ(IN_H), .ADDR_W(ADDR_W)) u_dec_h (
        .i_ofs    (w_nxt.nh),
        .i_scaled (w_nxt.ah),
        .o_valid  (w_valid_h),
        .o_idx    (w_row)
    );

    conv_t2d_axis_decode #(.STRIDE(STRIDE_W), .IN_SZ(IN_W), .ADDR_W(ADDR_W)) u_dec_w (
        .i_ofs    (w_nxt.nw),
        .i_scaled (w_nxt.nw),
        .o_valid  (w_valid_w),
        .o_idx    (w_col)
    );

    always_comb begin
        w_cmd          = '0;
        w_cmd.zero     = !(w_valid_h && w_valid_w);
        w_cmd.in_addr  = w_cmd.zero ? '0 : w_nxt.in_ic + w_row + w_col;
        w_cmd.w_addr   = w_nxt.w_oc + w_nxt.w_ic + w_nxt.w_k;
        w_cmd.out_addr = w_nxt.out_addr;
        w_cmd.first    = (w_nxt.ic == '0) && (w_nxt.kh == '0) && (w_nxt.kw == '0);
        w_cmd.last     = (w_nxt.ic == IC_MAX) && (w_nxt.kh == KH_MAX) && (w_nxt.kw == KW_MAX);
    end

    // Counters sit at the first beat whenever no pass is running, so start needs no extra load path.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_abort || (r_state != RUN) || w_final) r_loop <= LOOP_INIT;
        else if (w_fire)                                     r_loop <= w_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_abort || w_final) r_cmd <= '0;
        else if (w_start || w_fire)      r_cmd <= w_cmd;
    end

    assign o_cmd_in_addr  = r_cmd.in_addr;
    assign o_cmd_w_addr   = r_cmd.w_addr;
    assign o_cmd_out_addr = r_cmd.out_addr;
    assign o_cmd_zero     = r_cmd.zero;
    assign o_cmd_first    = r_cmd.first;
    assign o_cmd_last     = r_cmd.last;

endmodule
